// File: rtl/mem_access_ctrl.sv
// Memory access controller: routes pipeline loads/stores through a cache and backing memory.
// Optional build macro MEM_ACCESS_CTRL_PERF_EN adds cache hit/miss counters.
module mem_access_ctrl #(
    parameter int ADDRSIZE = 32,
    parameter int DATASIZE = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [ADDRSIZE-1:0] req_addr,
    input  logic [DATASIZE-1:0] req_wdata,
    input  logic [1:0]          req_len,
    input  logic                req_sign,
    output logic                stall,
    output logic                resp_valid,
    output logic [DATASIZE-1:0] resp_rdata,
    output logic                c_read,
    output logic                c_write,
    output logic                c_evict,
    output logic [ADDRSIZE-1:0] c_addr,
    output logic [ADDRSIZE-1:0] c_evaddr,
    output logic [DATASIZE-1:0] c_evdata,
    input  logic                c_done,
    input  logic                c_hit,
    input  logic [DATASIZE-1:0] c_dataout,
    output logic                m_read,
    output logic                m_write,
    output logic                m_sign,
    output logic [1:0]          m_len,
    output logic [ADDRSIZE-1:0] m_addr,
    output logic [DATASIZE-1:0] m_wdata,
    input  logic                m_ready,
`ifdef MEM_ACCESS_CTRL_PERF_EN
    output logic [31:0]         perf_hits,
    output logic [31:0]         perf_misses,
`endif
    input  logic [DATASIZE-1:0] m_rdata
);

    typedef enum logic [2:0] {IDLE, LOOKUP, MEMRD, FILL, MEMWR, RESP} state_t;

    state_t                state, nextState;
    logic [ADDRSIZE-1:0]   addrQ;
    logic [DATASIZE-1:0]   wdataQ;
    logic [DATASIZE-1:0]   rdataQ;
    logic [1:0]            lenQ;
    logic                  signQ;
    logic                  weQ;
    logic                  evictDone;
    logic                  latchReq;
    logic                  capCache;
    logic                  capMem;
    logic                  missEvt;
    logic                  lenIsWord;

    assign lenIsWord  = (lenQ == 2'b00) || (lenQ == 2'b11);
    assign resp_rdata = rdataQ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addrQ     <= '0;
            wdataQ    <= '0;
            rdataQ    <= '0;
            lenQ      <= '0;
            signQ     <= 1'b0;
            weQ       <= 1'b0;
            evictDone <= 1'b0;
        end else begin
            state     <= nextState;
            // Low only on the first FILL cycle, which is the single evict pulse.
            evictDone <= (state == FILL);
            if (latchReq) begin
                addrQ  <= req_addr;
                wdataQ <= req_wdata;
                lenQ   <= req_len;
                signQ  <= req_sign;
                weQ    <= req_we;
            end
            if (capCache) begin
                rdataQ <= c_dataout;
            end else if (capMem) begin
                rdataQ <= m_rdata;
            end
        end
    end

    always_comb begin
        nextState  = state;
        stall      = 1'b1;
        resp_valid = 1'b0;
        c_read     = 1'b0;
        c_write    = 1'b0;
        c_evict    = 1'b0;
        c_addr     = '0;
        c_evaddr   = '0;
        c_evdata   = '0;
        m_read     = 1'b0;
        m_write    = 1'b0;
        m_sign     = 1'b0;
        m_len      = 2'b00;
        m_addr     = '0;
        m_wdata    = '0;
        latchReq   = 1'b0;
        capCache   = 1'b0;
        capMem     = 1'b0;
        missEvt    = 1'b0;
        case (state)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    latchReq = 1'b1;
                    // Sub-word loads skip the cache and go straight to memory.
                    if (req_we || req_len == 2'b00 || req_len == 2'b11) begin
                        nextState = LOOKUP;
                    end else begin
                        nextState = MEMRD;
                    end
                end
            end
            LOOKUP: begin
                c_read  = !weQ;
                c_write = weQ;
                c_addr  = addrQ;
                if (c_done) begin
                    if (weQ) begin
                        nextState = MEMWR;
                    end else if (c_hit) begin
                        capCache  = 1'b1;
                        nextState = RESP;
                    end else begin
                        missEvt   = 1'b1;
                        nextState = MEMRD;
                    end
                end
            end
            MEMRD: begin
                m_read = 1'b1;
                m_addr = addrQ;
                m_len  = lenQ;
                m_sign = signQ;
                if (m_ready) begin
                    capMem    = 1'b1;
                    nextState = lenIsWord ? FILL : RESP;
                end
            end
            FILL: begin
                c_evict  = !evictDone;
                c_addr   = addrQ;
                c_evaddr = addrQ;
                c_evdata = rdataQ;
                if (evictDone && c_done) begin
                    nextState = RESP;
                end
            end
            MEMWR: begin
                m_write = 1'b1;
                m_addr  = addrQ;
                m_len   = lenQ;
                m_wdata = wdataQ;
                if (m_ready) begin
                    nextState = IDLE;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                nextState  = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

`ifdef MEM_ACCESS_CTRL_PERF_EN
    // Counters wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (capCache) perf_hits <= perf_hits + 32'd1;
            if (missEvt)  perf_misses <= perf_misses + 32'd1;
        end
    end
`endif

endmodule
